// File: rtl/operand_load_ctrl.sv
// Sequences one shared switch bus into the A, B and opcode enable-registers from a single load button.
// Both buttons are synchronized and edge-detected. Every output is registered.
module operand_load_ctrl #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          btn_load,
  input  logic          btn_clear,
  input  logic [DW-1:0] sw,
  output logic [DW-1:0] bus_d,
  output logic          en_a,
  output logic          en_b,
  output logic          en_op,
  output logic          clr_regs,
  output logic          op_valid,
  output logic [1:0]    state,
  output logic [7:0]    op_count
);

  typedef enum logic [1:0] {
    S_A    = 2'd0,
    S_B    = 2'd1,
    S_OP   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t        st_q, st_nx;
  logic [DW-1:0] bus_nx;
  logic          en_a_nx, en_b_nx, en_op_nx, clr_nx, vld_nx;
  logic [7:0]    cnt_nx;

  logic ld_s1, ld_s2, ld_s3, ld_arm;
  logic cl_s1, cl_s2, cl_s3, cl_arm;
  logic [1:0] rdy_q;
  logic ld_evt, cl_evt;

  // Synchronizer / edge-detect stage.
  // rdy_q marks when sync2 reflects the real button after reset; an edge only
  // counts once the button has been seen low, so a press held through reset is ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      ld_s1  <= 1'b0;
      ld_s2  <= 1'b0;
      ld_s3  <= 1'b0;
      cl_s1  <= 1'b0;
      cl_s2  <= 1'b0;
      cl_s3  <= 1'b0;
      rdy_q  <= 2'b00;
      ld_arm <= 1'b0;
      cl_arm <= 1'b0;
    end else begin
      ld_s1  <= btn_load;
      ld_s2  <= ld_s1;
      ld_s3  <= ld_s2;
      cl_s1  <= btn_clear;
      cl_s2  <= cl_s1;
      cl_s3  <= cl_s2;
      rdy_q  <= {rdy_q[0], 1'b1};
      ld_arm <= ld_arm | (rdy_q[1] & ~ld_s2);
      cl_arm <= cl_arm | (rdy_q[1] & ~cl_s2);
    end
  end

  assign ld_evt = ld_s2 & ~ld_s3 & ld_arm;
  assign cl_evt = cl_s2 & ~cl_s3 & cl_arm;

  // Sequencer next-state; clear has priority and swallows a coincident load.
  always_comb begin
    st_nx    = st_q;
    bus_nx   = bus_d;
    en_a_nx  = 1'b0;
    en_b_nx  = 1'b0;
    en_op_nx = 1'b0;
    clr_nx   = 1'b0;
    vld_nx   = op_valid;
    cnt_nx   = op_count;
    if (cl_evt) begin
      clr_nx = 1'b1;
      vld_nx = 1'b0;
      st_nx  = S_A;
      bus_nx = '0;
    end else if (ld_evt) begin
      bus_nx = sw;
      case (st_q)
        S_A: begin
          en_a_nx = 1'b1;
          st_nx   = S_B;
        end
        S_B: begin
          en_b_nx = 1'b1;
          st_nx   = S_OP;
        end
        S_OP: begin
          en_op_nx = 1'b1;
          vld_nx   = 1'b1;
          cnt_nx   = op_count + 8'd1;
          st_nx    = S_DONE;
        end
        default: begin
          en_a_nx = 1'b1;
          vld_nx  = 1'b0;
          st_nx   = S_B;
        end
      endcase
    end
  end

  // Output register stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q     <= S_A;
      bus_d    <= '0;
      en_a     <= 1'b0;
      en_b     <= 1'b0;
      en_op    <= 1'b0;
      clr_regs <= 1'b0;
      op_valid <= 1'b0;
      op_count <= 8'd0;
    end else begin
      st_q     <= st_nx;
      bus_d    <= bus_nx;
      en_a     <= en_a_nx;
      en_b     <= en_b_nx;
      en_op    <= en_op_nx;
      clr_regs <= clr_nx;
      op_valid <= vld_nx;
      op_count <= cnt_nx;
    end
  end

  assign state = st_q;

endmodule
